// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and sizing constants for the sprite draw scheduler.
package sprite_draw_scheduler_pkg;

  localparam int ROM_AW      = 12;
  localparam int COORD_W     = 10;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_LAUNCH,
    ST_WAIT,
    ST_FEND
  } state_t;

endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// Round-robin picker: first set bit of pending searching upward from ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          valid
);

  int idx;

  // Scan from the farthest offset down so the closest hit to ptr is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (pending[idx]) begin
        winner = IW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Per-frame scheduler: serves each requesting sprite once, hands geometry to the
// ROM-to-RAM reader and waits for completion or timeout.
module sprite_draw_scheduler
  import sprite_draw_scheduler_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frameStart,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ROM_AW-1:0]   reqRomAddr,
  input  logic [NUM_REQ*COORD_W-1:0]  reqX,
  input  logic [NUM_REQ*COORD_W-1:0]  reqY,
  input  logic [NUM_REQ*COORD_W-1:0]  reqWidth,
  input  logic [NUM_REQ*COORD_W-1:0]  reqHeight,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic                        frameDone,
  output logic                        beginDrawing,
  output logic [ROM_AW-1:0]           startROMAddr,
  output logic [COORD_W-1:0]          startX,
  output logic [COORD_W-1:0]          startY,
  output logic [COORD_W-1:0]          width,
  output logic [COORD_W-1:0]          height,
  input  logic                        doneDrawing,
  output logic [NUM_REQ-1:0]          timeoutErr,
  output logic                        overrun,
  input  logic                        clearErr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [ROM_AW-1:0]  rom_a [NUM_REQ];
  logic [COORD_W-1:0] x_a   [NUM_REQ];
  logic [COORD_W-1:0] y_a   [NUM_REQ];
  logic [COORD_W-1:0] w_a   [NUM_REQ];
  logic [COORD_W-1:0] h_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rom_a[gi] = reqRomAddr[gi*ROM_AW +: ROM_AW];
    assign x_a[gi]   = reqX[gi*COORD_W +: COORD_W];
    assign y_a[gi]   = reqY[gi*COORD_W +: COORD_W];
    assign w_a[gi]   = reqWidth[gi*COORD_W +: COORD_W];
    assign h_a[gi]   = reqHeight[gi*COORD_W +: COORD_W];
  end

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      winner_q, winner_d;
  logic [NUM_REQ-1:0] served_q, served_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] terr_q, terr_d;
  logic               overrun_q, overrun_d;
  logic [ROM_AW-1:0]  rom_q, rom_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;

  logic [NUM_REQ-1:0] pending;
  logic [IW-1:0]      arb_winner;
  logic               arb_valid;
  logic               zero_size;
  logic               cnt_hit;

  assign pending   = req & ~served_q;
  assign zero_size = (w_a[arb_winner] == '0) || (h_a[arb_winner] == '0);
  assign cnt_hit   = (cnt_q == CW'(TIMEOUT - 1));

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .pending (pending),
    .ptr     (ptr_q),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      winner_q  <= '0;
      served_q  <= '0;
      cnt_q     <= '0;
      ack_q     <= '0;
      terr_q    <= '0;
      overrun_q <= 1'b0;
      rom_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      served_q  <= served_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      terr_q    <= terr_d;
      overrun_q <= overrun_d;
      rom_q     <= rom_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (frameStart) state_d = ST_ARB;
      ST_ARB: begin
        if (!arb_valid)     state_d = ST_FEND;
        else if (zero_size) state_d = ST_ARB;
        else                state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (doneDrawing || cnt_hit) state_d = ST_ARB;
      ST_FEND:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; a new error always wins over a coincident clear.
  always_comb begin
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    served_d  = served_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    terr_d    = terr_q & ~{NUM_REQ{clearErr}};
    overrun_d = (overrun_q & ~clearErr) | (frameStart && (state_q != ST_IDLE));
    rom_d     = rom_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    unique case (state_q)
      ST_IDLE: if (frameStart) served_d = '0;
      ST_ARB: begin
        if (arb_valid) begin
          winner_d = arb_winner;
          rom_d    = rom_a[arb_winner];
          x_d      = x_a[arb_winner];
          y_d      = y_a[arb_winner];
          w_d      = w_a[arb_winner];
          h_d      = h_a[arb_winner];
          ptr_d    = (int'(arb_winner) == NUM_REQ - 1) ? '0 : arb_winner + 1'b1;
          if (zero_size) begin
            served_d[arb_winner] = 1'b1;
            ack_d[arb_winner]    = 1'b1;
          end
        end
      end
      ST_LAUNCH: cnt_d = '0;
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (doneDrawing || cnt_hit) begin
          served_d[winner_q] = 1'b1;
          ack_d[winner_q]    = 1'b1;
          if (!doneDrawing) terr_d[winner_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    beginDrawing = (state_q == ST_LAUNCH);
    frameDone    = (state_q == ST_FEND);
  end

  assign ack          = ack_q;
  assign timeoutErr   = terr_q;
  assign overrun      = overrun_q;
  assign startROMAddr = rom_q;
  assign startX       = x_q;
  assign startY       = y_q;
  assign width        = w_q;
  assign height       = h_q;

endmodule
